// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: retires PAIRS_PER_CYCLE multiplier bit-pairs per
// cycle into a 2*WIDTH+4 bit accumulator, then publishes the low 2*WIDTH bits on z.
module booth_pp #(
  parameter int AW = 36
) (
  input  logic [2:0]    trip,
  input  logic [AW-1:0] mcand,
  output logic [AW-1:0] pp
);
  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end
endmodule

module booth_seq_mult #(
  parameter int WIDTH           = 32,
  parameter int PAIRS_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);
  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int P  = PAIRS_PER_CYCLE;
  localparam int C  = (N + P - 1) / P;
  localparam int MW = 2 * P * C;   // multiplier reg covers every pair visited, incl. padding
  localparam int AW = 2 * WIDTH + 4;
  localparam int CW = $clog2(C + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [MW-1:0]      mr_q, mr_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic               prev_q, prev_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [E-1:0]              a_ext, b_ext;
  logic [MW-1:0]             mr_load;
  logic [AW-1:0]             mcand_load;
  logic [P-1:0][2:0]         trip;
  logic [P-1:0][AW-1:0]      mc_lane, pp;
  logic [AW-1:0]             pp_sum, acc_sum;

  // Unsigned operands get two zero bits on top, so both modes share the signed datapath.
  always_comb begin
    a_ext      = {{2{signed_mode & a[WIDTH-1]}}, a};
    b_ext      = {{2{signed_mode & b[WIDTH-1]}}, b};
    mr_load    = MW'($signed(a_ext));
    mcand_load = AW'($signed(b_ext));
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    if (j == 0) begin : g_first
      assign trip[j] = {mr_q[1:0], prev_q};
    end else begin : g_rest
      assign trip[j] = mr_q[2*j+1 -: 3];
    end
    assign mc_lane[j] = mcand_q << (2 * j);
    booth_pp #(.AW(AW)) u_pp (
      .trip  (trip[j]),
      .mcand (mc_lane[j]),
      .pp    (pp[j])
    );
  end

  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < P; j++) pp_sum = pp_sum + pp[j];
    acc_sum = acc_q + pp_sum;
  end

  always_comb begin
    state_d = state_q;
    mr_d    = mr_q;
    mcand_d = mcand_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          mr_d    = mr_load;
          mcand_d = mcand_load;
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = CW'(C);
          state_d = RUN;
        end
      end
      RUN: begin
        // Arithmetic shift keeps padding pairs at 000/111, so they add nothing.
        acc_d   = acc_sum;
        mr_d    = MW'($signed(mr_q) >>> (2 * P));
        mcand_d = mcand_q << (2 * P);
        prev_d  = mr_q[2*P-1];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          z_d     = acc_sum[2*WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      mr_q    <= '0;
      mcand_q <= '0;
      prev_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mr_q    <= mr_d;
      mcand_q <= mcand_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Randomized self-checking bench: a 32-bit/1-pair and a 16-bit/4-pair multiplier against
// a plain-arithmetic product model, with latency, busy, hold, restart and reset checks.
module tb_booth_seq_mult;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear_n;
  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] z32;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] z16;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last32, last16;

  booth_seq_mult dut32 (
    .clock(clock), .clear_n(clear_n), .start(start32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .z(z32)
  );

  booth_seq_mult #(.WIDTH(16), .PAIRS_PER_CYCLE(4)) dut16 (
    .clock(clock), .clear_n(clear_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .z(z16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit w16, input logic [31:0] ta,
                                          input logic [31:0] tb, input bit ts);
    longint x, y, p;
    if (w16) begin
      x = ts ? longint'($signed(ta[15:0])) : longint'(ta[15:0]);
      y = ts ? longint'($signed(tb[15:0])) : longint'(tb[15:0]);
    end else begin
      x = ts ? longint'($signed(ta)) : longint'(ta);
      y = ts ? longint'($signed(tb)) : longint'(tb);
    end
    p = x * y;
    return w16 ? {32'b0, p[31:0]} : 64'(p);
  endfunction

  task automatic drive(input bit w16, input logic [31:0] ta, input logic [31:0] tb,
                       input bit ts, input bit st);
    if (w16) begin
      a16 = ta[15:0]; b16 = tb[15:0]; sm16 = ts; start16 = st;
    end else begin
      a32 = ta; b32 = tb; sm32 = ts; start32 = st;
    end
  endtask

  function automatic logic cur_done(input bit w16);
    return w16 ? done16 : done32;
  endfunction

  function automatic logic cur_busy(input bit w16);
    return w16 ? busy16 : busy32;
  endfunction

  function automatic logic [63:0] cur_z(input bit w16);
    return w16 ? {32'b0, z16} : z32;
  endfunction

  // Called at a negedge; returns at the negedge where done is first seen high.
  // Operands are scrambled during the run, and start is re-pulsed at 'repulse' if >= 2.
  task automatic run_mul(input bit w16, input logic [31:0] ta, input logic [31:0] tb,
                         input bit ts, input int repulse);
    int edges, busycnt, cc;
    logic [63:0] exp, zprev;
    cc    = w16 ? 3 : 17;
    exp   = ref_mul(w16, ta, tb, ts);
    zprev = w16 ? last16 : last32;
    drive(w16, ta, tb, ts, 1'b1);
    @(posedge clock); @(negedge clock);
    edges   = 1;
    busycnt = cur_busy(w16) ? 1 : 0;
    chk("z_hold_on_start", cur_z(w16), zprev);
    drive(w16, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    while (!cur_done(w16) && edges < 60) begin
      @(posedge clock); @(negedge clock);
      edges++;
      if (cur_busy(w16)) busycnt++;
      drive(w16, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'(edges == repulse));
    end
    chk(w16 ? "latency16" : "latency32", 64'(edges), 64'(cc + 1));
    chk(w16 ? "busy_cycles16" : "busy_cycles32", 64'(busycnt), 64'(cc));
    chk(w16 ? "product16" : "product32", cur_z(w16), exp);
    if (w16) last16 = exp; else last32 = exp;
    drive(w16, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic idle_chk(input bit w16);
    @(posedge clock); @(negedge clock);
    chk("done_one_cycle", 64'(cur_done(w16)), 64'd0);
    chk("busy_after_done", 64'(cur_busy(w16)), 64'd0);
    chk("z_held_idle", cur_z(w16), w16 ? last16 : last32);
  endtask

  initial begin
    int dn;
    bit w;
    logic [31:0] ra, rb;
    clear_n = 1'b0;
    drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 32'h0, 32'h0, 1'b0, 1'b0);
    last32 = '0;
    last16 = '0;
    start32 = 1'b1;   // must be ignored while clear_n is low
    repeat (3) @(negedge clock);
    start32 = 1'b0;
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_z32", z32, 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_z16", {32'b0, z16}, 64'd0);
    clear_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("no_start_after_rst", 64'(busy32), 64'd0);

    // Directed boundary vectors
    run_mul(0, 32'hFFFF_FFFD, 32'h7, 1'b1, 0);
    idle_chk(0);
    run_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);   // back-to-back from DONE
    idle_chk(0);
    run_mul(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    run_mul(0, 32'h8000_0000, 32'h1, 1'b1, 0);
    run_mul(0, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
    run_mul(0, 32'h8000_0000, 32'h0, 1'b1, 0);
    idle_chk(0);
    run_mul(1, 32'hFFFF, 32'h1234, 1'b0, 0);
    idle_chk(1);
    run_mul(1, 32'h8000, 32'h8000, 1'b1, 0);
    run_mul(1, 32'hFFFF, 32'hFFFF, 1'b0, 0);
    run_mul(1, 32'h8000, 32'h7FFF, 1'b1, 2);
    idle_chk(1);

    // Re-pulsed start mid-run, then a back-to-back start from DONE
    run_mul(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5);
    run_mul(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 0);
    idle_chk(0);

    // Reset dropped mid-run: outputs clear at once and no done follows
    drive(0, 32'h7, 32'h9, 1'b0, 1'b1);
    @(posedge clock); @(negedge clock);
    drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (7) begin @(posedge clock); @(negedge clock); end
    clear_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 64'(busy32), 64'd0);
    chk("midrun_rst_done", 64'(done32), 64'd0);
    chk("midrun_rst_z32", z32, 64'd0);
    chk("midrun_rst_z16", {32'b0, z16}, 64'd0);
    start32 = 1'b1;
    dn = 0;
    repeat (6) begin @(negedge clock); dn += int'(done32) + int'(busy32); end
    start32 = 1'b0;
    clear_n = 1'b1;
    last32 = '0;
    last16 = '0;
    repeat (20) begin @(negedge clock); dn += int'(done32) + int'(busy32); end
    chk("no_activity_after_rst", 64'(dn), 64'd0);
    run_mul(0, 32'h7, 32'h9, 1'b0, 0);
    idle_chk(0);

    // Randomized operands, modes and widths; some boundary picks mixed in
    for (int i = 0; i < 30; i++) begin
      w  = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = w ? 32'h8000 : 32'h8000_0000;
        1: rb = w ? 32'hFFFF : 32'hFFFF_FFFF;
        2: ra = 32'h0;
        default: ;
      endcase
      run_mul(w, ra, rb, 1'($urandom_range(0, 1)),
              w ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 16)));
      if ($urandom_range(0, 1) == 1) idle_chk(w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
